// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the Lab2 control unit.
//   - datapath/instruction width N and address/PC width AW
//   - opcode constants OP_LOAD .. OP_HALT (IR[7:5])
//   - Asel source codes for the accumulator datapath
//   - FSM state encoding (state_e)
//   - pc_inc(): program-counter increment, wraps modulo 2^AW
// Optional feature macro: CTRL_UNIT_SINGLE_STEP_EN (adds ST_STEP_WAIT).
package ctrl_pkg;

  localparam int N  = 8;
  localparam int AW = 5;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_SUM = 2'b00;
  localparam logic [1:0] ASEL_MEM = 2'b01;
  localparam logic [1:0] ASEL_IN  = 2'b10;

  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXEC      = 3'd3,
    ST_LOAD2     = 3'd4,
    ST_HALT      = 3'd5
`ifdef CTRL_UNIT_SINGLE_STEP_EN
    , ST_STEP_WAIT = 3'd6
`endif
  } state_e;

  // Natural AW-bit overflow gives the required 31 -> 0 wrap.
  function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] pc);
    return pc + {{(AW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/ctrl_unit_if.sv
// ctrl_unit_if: memory bus and accumulator-datapath control/status bundle.
//   mem_addr  (AW) memory address             mem_we  memory write strobe
//   mem_rdata (N)  memory read data           Aload   accumulator load enable
//   Sub            1 = subtract, 0 = add      Asel    datapath source select
//   Apos           A[N-1]==0                  Aeq0    A==0
// master: the control unit; slave: memory + datapath side.
interface ctrl_unit_if;
  import ctrl_pkg::*;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [N-1:0]  mem_rdata;
  logic          Aload;
  logic          Sub;
  logic [1:0]    Asel;
  logic          Apos;
  logic          Aeq0;

  modport master (
    output mem_addr, mem_we, Aload, Sub, Asel,
    input  mem_rdata, Apos, Aeq0
  );

  modport slave (
    input  mem_addr, mem_we, Aload, Sub, Asel,
    output mem_rdata, Apos, Aeq0
  );

endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational Moore decode of the control outputs.
//   state_i       current FSM state       opcode_i     IR[7:5]
//   aeq0_i/apos_i datapath status flags (only used for jump_take_o)
//   aload_o, sub_o, asel_o, mem_we_o   datapath / memory controls
//   addr_sel_ir_o 1 = memory address from IR[4:0], 0 = from pc
//   jump_take_o   conditional jump taken (EXEC of JZ/JPOS only)
// Controls depend on state and opcode only; flags affect jump_take_o alone.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [2:0]  opcode_i,
  input  logic        aeq0_i,
  input  logic        apos_i,
  output logic        aload_o,
  output logic        sub_o,
  output logic [1:0]  asel_o,
  output logic        mem_we_o,
  output logic        addr_sel_ir_o,
  output logic        jump_take_o
);

  // Control and jump decode per state/opcode; everything idles at 0.
  always_comb begin
    aload_o       = 1'b0;
    sub_o         = 1'b0;
    asel_o        = ASEL_SUM;
    mem_we_o      = 1'b0;
    addr_sel_ir_o = 1'b0;
    jump_take_o   = 1'b0;
    case (state_i)
      ST_EXEC: begin
        addr_sel_ir_o = 1'b1;
        case (opcode_i)
          OP_STORE: mem_we_o = 1'b1;
          OP_ADD: begin
            aload_o = 1'b1;
            asel_o  = ASEL_SUM;
          end
          OP_SUB: begin
            aload_o = 1'b1;
            sub_o   = 1'b1;
            asel_o  = ASEL_SUM;
          end
          OP_IN: begin
            aload_o = 1'b1;
            asel_o  = ASEL_IN;
          end
          OP_JZ:   jump_take_o = aeq0_i;
          OP_JPOS: jump_take_o = apos_i;
          // LOAD loads in LOAD2; HALT issues nothing.
          default: jump_take_o = 1'b0;
        endcase
      end
      ST_LOAD2: begin
        addr_sel_ir_o = 1'b1;
        aload_o       = 1'b1;
        asel_o        = ASEL_MEM;
      end
      default: aload_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit: Lab2 processor control FSM (START/FETCH/DECODE/EXEC/LOAD2/HALT).
// Ports:
//   clock   system clock, rising edge
//   reset   synchronous active-low reset
//   enter   start pulse, only honoured in START
//   step    (CTRL_UNIT_SINGLE_STEP_EN only) releases STEP_WAIT
//   bus     ctrl_unit_if.master: memory bus, datapath controls and flags
//   pc      program counter
//   halted  high in HALT
// Optional feature macro: CTRL_UNIT_SINGLE_STEP_EN. When defined, each
// instruction ends in STEP_WAIT and waits for step=1 before the next FETCH.
// State, PC and IR live here; output decode lives in ctrl_decode.
module ctrl_unit
  import ctrl_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          enter,
`ifdef CTRL_UNIT_SINGLE_STEP_EN
  input  logic          step,
`endif
  ctrl_unit_if.master   bus,
  output logic [AW-1:0] pc,
  output logic          halted
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [N-1:0]  ir_q, ir_d;

  logic [2:0]    opcode_s;
  logic [AW-1:0] ir_addr_s;
  logic          addr_sel_ir_s;
  logic          jump_take_s;
  state_e        done_state_s;

  assign opcode_s  = ir_q[N-1 -: 3];
  assign ir_addr_s = ir_q[AW-1:0];

`ifdef CTRL_UNIT_SINGLE_STEP_EN
  assign done_state_s = ST_STEP_WAIT;
`else
  assign done_state_s = ST_FETCH;
`endif

  ctrl_decode u_decode (
    .state_i       (state_q),
    .opcode_i      (opcode_s),
    .aeq0_i        (bus.Aeq0),
    .apos_i        (bus.Apos),
    .aload_o       (bus.Aload),
    .sub_o         (bus.Sub),
    .asel_o        (bus.Asel),
    .mem_we_o      (bus.mem_we),
    .addr_sel_ir_o (addr_sel_ir_s),
    .jump_take_o   (jump_take_s)
  );

  // Outputs are decoded purely from registered state, PC and IR.
  assign bus.mem_addr = addr_sel_ir_s ? ir_addr_s : pc_q;
  assign pc           = pc_q;
  assign halted       = (state_q == ST_HALT);

  // Next-state, PC and IR logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_START: begin
        if (enter) state_d = ST_FETCH;
        else       state_d = ST_START;
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        // Read data for the FETCH address arrives this cycle.
        ir_d    = bus.mem_rdata;
        pc_d    = pc_inc(pc_q);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // pc already holds pc+1 here, so a taken jump simply overwrites it.
        if (jump_take_s) pc_d = ir_addr_s;
        else             pc_d = pc_q;
        case (opcode_s)
          OP_LOAD: state_d = ST_LOAD2;
          OP_HALT: state_d = ST_HALT;
          default: state_d = done_state_s;
        endcase
      end
      ST_LOAD2: state_d = done_state_s;
      ST_HALT:  state_d = ST_HALT;
`ifdef CTRL_UNIT_SINGLE_STEP_EN
      ST_STEP_WAIT: begin
        if (step) state_d = ST_FETCH;
        else      state_d = ST_STEP_WAIT;
      end
`endif
      default: state_d = ST_START;
    endcase
  end

  // State, PC and IR registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_START;
      pc_q    <= {AW{1'b0}};
      ir_q    <= {N{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: self-checking bench for ctrl_unit. Provides a memory and an
// accumulator datapath around the DUT, applies a table of single-instruction
// vectors, a few hand-written multi-cycle sequences and random programs
// checked against an instruction-level reference model.
`timescale 1ns/1ps
module tb_ctrl_unit;
  import ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic enter;
`ifdef CTRL_UNIT_SINGLE_STEP_EN
  logic step;
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif
  logic [4:0] pc;
  logic       halted;

  ctrl_unit_if bus();

  ctrl_unit dut (
    .clock  (clock),
    .reset  (reset),
    .enter  (enter),
`ifdef CTRL_UNIT_SINGLE_STEP_EN
    .step   (step),
`endif
    .bus    (bus),
    .pc     (pc),
    .halted (halted)
  );

  always #5 clock = ~clock;

  // ---------------- environment: memory + accumulator ----------------
  logic [7:0] mem [32];
  logic [7:0] img [32];
  logic [7:0] acc, dp1, rdata;
  logic       ld_en;
  logic [4:0] ld_addr;
  logic [7:0] ld_data;
  logic       a_set;
  logic [7:0] a_set_val;

  assign bus.mem_rdata = rdata;
  assign bus.Apos      = ~acc[7];
  assign bus.Aeq0      = (acc == 8'h00);

  // Memory: bench load port, DUT store port, one-cycle read latency.
  always_ff @(posedge clock) begin
    if (ld_en)            mem[ld_addr]      <= ld_data;
    else if (bus.mem_we)  mem[bus.mem_addr] <= acc;
    rdata <= mem[bus.mem_addr];
  end

  // Accumulator datapath.
  always_ff @(posedge clock) begin
    if (a_set) acc <= a_set_val;
    else if (bus.Aload) begin
      case (bus.Asel)
        2'b00:   acc <= bus.Sub ? acc - dp1 : acc + dp1;
        2'b01:   acc <= rdata;
        2'b10:   acc <= dp1;
        default: acc <= 8'hxx;
      endcase
    end
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [9:0] ctl(input logic al, input logic sb, input logic [1:0] as,
                                     input logic we, input logic [4:0] ad);
    return {al, sb, as, we, ad};
  endfunction

  function automatic logic [9:0] ctl_now();
    return {bus.Aload, bus.Sub, bus.Asel, bus.mem_we, bus.mem_addr};
  endfunction

  // Hold reset, load img into memory, preset A and dp1In, check reset
  // outputs, then release reset with enter high for one edge (-> FETCH).
  task automatic start_run(input logic [7:0] a0, input logic [7:0] d);
    reset     = 1'b0;
    enter     = 1'b0;
    a_set     = 1'b1;
    a_set_val = a0;
    dp1       = d;
    for (int i = 0; i < 32; i++) begin
      ld_en   = 1'b1;
      ld_addr = 5'(i);
      ld_data = img[i];
      tick();
    end
    ld_en = 1'b0;
    a_set = 1'b0;
    check("reset_state", {16'd0, halted, pc, ctl_now()}, 32'd0);
    reset = 1'b1;
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  // ---------------- instruction-level reference model ----------------
  typedef struct packed {
    logic       halted;
    logic [4:0] pc;
    logic       aload;
    logic       sub;
    logic [1:0] asel;
    logic       we;
    logic [4:0] addr;
    logic       chk_addr;
  } cyc_t;

  cyc_t exp_q[$];

  function automatic cyc_t mk(input logic h, input logic [4:0] p, input logic al, input logic sb,
                              input logic [1:0] as, input logic we, input logic [4:0] ad,
                              input logic ck);
    cyc_t c;
    c.halted = h; c.pc = p; c.aload = al; c.sub = sb; c.asel = as;
    c.we = we; c.addr = ck ? ad : 5'd0; c.chk_addr = ck;
    return c;
  endfunction

  // Interpret the program in img and list the expected outputs cycle by
  // cycle, starting at the first FETCH.
  task automatic build_trace(input logic [7:0] a0, input logic [7:0] d, input int budget);
    logic [7:0] m [32];
    logic [7:0] a;
    logic [7:0] ir;
    logic [4:0] p, ad;
    bit         done;
    m = img; a = a0; p = 5'd0; done = 1'b0;
    exp_q.delete();
    while (exp_q.size() < budget && !done) begin
      ir = m[p];
      ad = ir[4:0];
      exp_q.push_back(mk(1'b0, p, 1'b0, 1'b0, 2'b00, 1'b0, p, 1'b1));     // FETCH
      exp_q.push_back(mk(1'b0, p, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0));  // DECODE
      p = p + 5'd1;
      case (ir[7:5])
        3'd0: begin
          exp_q.push_back(mk(1'b0, p, 1'b0, 1'b0, 2'b00, 1'b0, ad, 1'b1));
          exp_q.push_back(mk(1'b0, p, 1'b1, 1'b0, 2'b01, 1'b0, ad, 1'b1));
          a = m[ad];
        end
        3'd1: begin
          exp_q.push_back(mk(1'b0, p, 1'b0, 1'b0, 2'b00, 1'b1, ad, 1'b1));
          m[ad] = a;
        end
        3'd2: begin
          exp_q.push_back(mk(1'b0, p, 1'b1, 1'b0, 2'b00, 1'b0, ad, 1'b1));
          a = a + d;
        end
        3'd3: begin
          exp_q.push_back(mk(1'b0, p, 1'b1, 1'b1, 2'b00, 1'b0, ad, 1'b1));
          a = a - d;
        end
        3'd4: begin
          exp_q.push_back(mk(1'b0, p, 1'b1, 1'b0, 2'b10, 1'b0, ad, 1'b1));
          a = d;
        end
        3'd5: begin
          exp_q.push_back(mk(1'b0, p, 1'b0, 1'b0, 2'b00, 1'b0, ad, 1'b1));
          if (a == 8'd0) p = ad;
        end
        3'd6: begin
          exp_q.push_back(mk(1'b0, p, 1'b0, 1'b0, 2'b00, 1'b0, ad, 1'b1));
          if (a[7] == 1'b0) p = ad;
        end
        default: begin
          exp_q.push_back(mk(1'b0, p, 1'b0, 1'b0, 2'b00, 1'b0, ad, 1'b1));
          while (exp_q.size() < budget)
            exp_q.push_back(mk(1'b1, p, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0));
          done = 1'b1;
        end
      endcase
      if (STEP_EN && !done)
        exp_q.push_back(mk(1'b0, p, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0));
    end
  endtask

  function automatic cyc_t observe(input logic ck);
    return mk(halted, pc, bus.Aload, bus.Sub, bus.Asel, bus.mem_we, bus.mem_addr, ck);
  endfunction

  // ---------------- single-instruction vector table ----------------
  typedef struct {
    logic [7:0] instr;
    logic [7:0] a0;
    logic [7:0] dp;
    logic [9:0] exec_ctl;
    bit         load2;
    logic [4:0] pc_after;
    logic [7:0] a_after;
    bit         halt_after;
  } vec_t;

  vec_t vt[11];

  initial begin
    reset = 1'b0;
    enter = 1'b0;
    ld_en = 1'b0;
    a_set = 1'b0;
    a_set_val = 8'd0;
    dp1 = 8'd0;
    ld_addr = 5'd0;
    ld_data = 8'd0;
`ifdef CTRL_UNIT_SINGLE_STEP_EN
    step = 1'b1;
`endif

    vt[0]  = '{8'h80, 8'h00, 8'd5, ctl(1'b1, 1'b0, 2'b10, 1'b0, 5'd0), 1'b0, 5'd1, 8'd5,  1'b0};
    vt[1]  = '{8'h45, 8'h03, 8'd5, ctl(1'b1, 1'b0, 2'b00, 1'b0, 5'd5), 1'b0, 5'd1, 8'd8,  1'b0};
    vt[2]  = '{8'h65, 8'h05, 8'd5, ctl(1'b1, 1'b1, 2'b00, 1'b0, 5'd5), 1'b0, 5'd1, 8'd0,  1'b0};
    vt[3]  = '{8'h65, 8'h02, 8'd5, ctl(1'b1, 1'b1, 2'b00, 1'b0, 5'd5), 1'b0, 5'd1, 8'hFD, 1'b0};
    vt[4]  = '{8'h29, 8'h33, 8'd0, ctl(1'b0, 1'b0, 2'b00, 1'b1, 5'd9), 1'b0, 5'd1, 8'h33, 1'b0};
    vt[5]  = '{8'h03, 8'h11, 8'd0, ctl(1'b0, 1'b0, 2'b00, 1'b0, 5'd3), 1'b1, 5'd1, 8'h2A, 1'b0};
    vt[6]  = '{8'hA7, 8'h00, 8'd0, ctl(1'b0, 1'b0, 2'b00, 1'b0, 5'd7), 1'b0, 5'd7, 8'h00, 1'b0};
    vt[7]  = '{8'hA7, 8'h01, 8'd0, ctl(1'b0, 1'b0, 2'b00, 1'b0, 5'd7), 1'b0, 5'd1, 8'h01, 1'b0};
    vt[8]  = '{8'hC7, 8'h80, 8'd0, ctl(1'b0, 1'b0, 2'b00, 1'b0, 5'd7), 1'b0, 5'd1, 8'h80, 1'b0};
    vt[9]  = '{8'hC7, 8'h7F, 8'd0, ctl(1'b0, 1'b0, 2'b00, 1'b0, 5'd7), 1'b0, 5'd7, 8'h7F, 1'b0};
    vt[10] = '{8'hE0, 8'h00, 8'd0, ctl(1'b0, 1'b0, 2'b00, 1'b0, 5'd0), 1'b0, 5'd1, 8'h00, 1'b1};

    for (int v = 0; v < 11; v++) begin
      for (int i = 0; i < 32; i++) img[i] = 8'hE0;
      img[0] = vt[v].instr;
      img[3] = 8'h2A;
      start_run(vt[v].a0, vt[v].dp);
      check("fetch_addr", {22'd0, ctl_now()}, {22'd0, ctl(1'b0, 1'b0, 2'b00, 1'b0, 5'd0)});
      tick();
      tick();
      check("exec_ctl", {22'd0, ctl_now()}, {22'd0, vt[v].exec_ctl});
      check("exec_pc", {27'd0, pc}, 32'd1);
      if (vt[v].load2) begin
        tick();
        check("load2_ctl", {22'd0, ctl_now()}, {22'd0, ctl(1'b1, 1'b0, 2'b01, 1'b0, vt[v].instr[4:0])});
      end
      tick();
      check("after_state", {26'd0, halted, pc}, {26'd0, vt[v].halt_after, vt[v].pc_after});
      check("after_ctl", {27'd0, bus.Aload, bus.Sub, bus.Asel, bus.mem_we}, 32'd0);
      check("after_acc", {24'd0, acc}, {24'd0, vt[v].a_after});
      if (!vt[v].halt_after)
        check("after_addr", {27'd0, bus.mem_addr}, {27'd0, vt[v].pc_after});
      if (vt[v].instr[7:5] == 3'b001)
        check("store_mem", {24'd0, mem[vt[v].instr[4:0]]}, {24'd0, vt[v].a0});
    end

    // pc wrap: JZ 31 taken, IN at 31, pc must read 0 in its EXEC.
    for (int i = 0; i < 32; i++) img[i] = 8'hE0;
    img[0]  = 8'hBF;
    img[31] = 8'h80;
    start_run(8'h00, 8'd9);
    tick();
    tick();
    tick();
    if (STEP_EN) tick();
    check("wrap_fetch", {27'd0, pc}, 32'd31);
    tick();
    tick();
    check("wrap_pc", {27'd0, pc}, 32'd0);
    check("wrap_ctl", {22'd0, ctl_now()}, {22'd0, ctl(1'b1, 1'b0, 2'b10, 1'b0, 5'd0)});

    // HALT is sticky: enter pulses change nothing.
    for (int i = 0; i < 32; i++) img[i] = 8'hE0;
    start_run(8'h00, 8'd0);
    tick();
    tick();
    tick();
    check("halt_enter", {26'd0, halted, pc}, {26'd0, 1'b1, 5'd1});
    for (int k = 0; k < 3; k++) begin
      enter = 1'b1;
      tick();
      enter = 1'b0;
      tick();
      check("halt_hold", {21'd0, halted, pc, bus.Aload, bus.Sub, bus.Asel, bus.mem_we},
            {21'd0, 1'b1, 5'd1, 5'd0});
    end

    // Reset during LOAD2 aborts the instruction.
    for (int i = 0; i < 32; i++) img[i] = 8'hE0;
    img[0] = 8'h03;
    img[3] = 8'h2A;
    start_run(8'h11, 8'd0);
    tick();
    tick();
    tick();
    check("rst_load2", {31'd0, bus.Aload}, 32'd1);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst_abort", {16'd0, halted, pc, ctl_now()}, 32'd0);
    end
    reset = 1'b1;
    tick();
    check("rst_idle", {16'd0, halted, pc, ctl_now()}, 32'd0);

`ifdef CTRL_UNIT_SINGLE_STEP_EN
    // STEP_WAIT holds until step is pulsed.
    for (int i = 0; i < 32; i++) img[i] = 8'hE0;
    img[0] = 8'h80;
    img[1] = 8'h80;
    step = 1'b0;
    start_run(8'h00, 8'd4);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      check("step_wait", {26'd0, bus.Aload, pc}, {26'd0, 1'b0, 5'd1});
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    check("step_exec", {26'd0, bus.Aload, pc}, {26'd0, 1'b1, 5'd2});
    step = 1'b1;
`endif

    // Random programs against the reference model; enter is held high
    // for the first cycles to show it only starts execution once.
    for (int r = 0; r < 20; r++) begin
      logic [7:0] a0, d;
      for (int i = 0; i < 32; i++)
        img[i] = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      a0 = 8'($urandom_range(0, 255));
      d  = 8'($urandom_range(0, 255));
      build_trace(a0, d, 100);
      start_run(a0, d);
      enter = 1'b1;
      for (int c = 0; c < 100; c++) begin
        if (c == 3) enter = 1'b0;
        check("rand_cycle", {15'd0, observe(exp_q[c].chk_addr)}, {15'd0, exp_q[c]});
        tick();
      end
      enter = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_unit.md
# ctrl_unit

Control-unit FSM for the Lab2 processor: fetches 8-bit instructions from a 32-word program memory, decodes them, and drives the accumulator datapath's `Aload`, `Sub` and `Asel` controls. It consumes the datapath's `Apos` and `Aeq0` status flags for conditional jumps. It sits directly upstream of the accumulator datapath and alongside the program/data memory.

## Interface
- `n`, 8, datapath and instruction width
- `AW`, 5, memory address width; also the PC width
- `clock`  in  1  system clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-low reset
- `enter`  in  1  start pulse; leaves START
- `Apos`  in  1  datapath flag: A[n-1]==0
- `Aeq0`  in  1  datapath flag: A==0
- `mem_rdata`  in  n  memory read data; valid one cycle after `mem_addr`
- `mem_addr`  out  AW  memory address
- `mem_we`  out  1  memory write strobe; memory stores the datapath's `mOutput`
- `Aload`  out  1  accumulator load enable
- `Sub`  out  1  1 = subtract, 0 = add
- `Asel`  out  2  datapath source select: 00 add/sub result, 01 `mInput`, 10 `dp1In`
- `pc`  out  AW  program counter
- `halted`  out  1  high in HALT state

## Operation
- Instruction format: opcode = IR[7:5], address = IR[4:0].
- Opcodes:
  - 000 LOAD: A <= M[addr]
  - 001 STORE: M[addr] <= A
  - 010 ADD: A <= A + dp1In
  - 011 SUB: A <= A - dp1In
  - 100 IN: A <= dp1In
  - 101 JZ: if Aeq0, PC <= addr
  - 110 JPOS: if Apos, PC <= addr
  - 111 HALT
- States: START, FETCH, DECODE, EXEC, LOAD2, HALT.
- START: all controls 0. Goes to FETCH when `enter`=1.
- FETCH: `mem_addr`=pc. Goes to DECODE.
- DECODE: IR <= `mem_rdata`; pc <= pc+1, wrapping modulo 2^AW (31→0). Goes to EXEC.
- EXEC: `mem_addr`=IR[4:0] for all opcodes.
  - LOAD: goes to LOAD2; no Aload this cycle.
  - STORE: `mem_we`=1.
  - ADD: Aload=1, Asel=00, Sub=0.
  - SUB: Aload=1, Asel=00, Sub=1.
  - IN: Aload=1, Asel=10.
  - JZ/JPOS: flags are sampled this cycle; they reflect A after the previous instruction. pc <= IR[4:0] if the condition holds.
  - HALT: goes to HALT.
  - All opcodes other than LOAD and HALT go to FETCH.
- LOAD2: `mem_addr`=IR[4:0]; Aload=1, Asel=01 (memory data routed to `mInput`). Goes to FETCH.
- HALT: `halted`=1, all controls 0. Stays until reset; `enter` is ignored.
- Asel=11 is never driven.
- Control outputs are combinational from state and IR only (Moore); they never depend on `enter` or the flags.
- A jump takes priority over the pc+1 from DECODE because the two occur in different cycles.
- A jump to the jump's own address is legal and loops forever.

## Timing
- Cycles per instruction: 3 (FETCH, DECODE, EXEC); LOAD takes 4.
- `mem_rdata` is captured in DECODE and in LOAD2, one cycle after the address is presented.
- Reset, sampled at any clock edge with `reset`=0, forces on the next state:
  - state=START, pc=0, IR=0
  - Aload=Sub=mem_we=halted=0, Asel=00, `mem_addr`=0
- Reset mid-instruction aborts it: no Aload or mem_we is issued after the reset edge.
- `enter` held high across several cycles starts execution exactly once; START is not re-entered except by reset.
- `mem_we` is high for exactly one cycle per STORE.

## Configuration
- `CTRL_UNIT_SINGLE_STEP_EN`
- Defined:
  - Adds input port `step` (1 bit) and state STEP_WAIT.
  - Each instruction's final state (EXEC, or LOAD2 for LOAD) goes to STEP_WAIT instead of FETCH.
  - STEP_WAIT drives all controls 0 and goes to FETCH on the first cycle `step`=1.
  - HALT is unaffected.
- Undefined: no `step` port, no STEP_WAIT state; timing as above.

## Structure
- Shared package `ctrl_pkg` holds:
  - opcode constants (OP_LOAD … OP_HALT)
  - state encoding
  - Asel codes (ASEL_SUM=00, ASEL_MEM=01, ASEL_IN=10)
- One natural sub-module: `ctrl_decode`, combinational.
  - Inputs: state, opcode, Aeq0, Apos.
  - Outputs: Aload, Sub, Asel, mem_we, mem_addr select, jump_take.
- PC, IR and the state register live in `ctrl_unit`.

## Test plan
- Reset then `enter`; M[0]=100_00000 (IN), dp1In=5 → Aload=1, Asel=10 in cycle 3 after FETCH; pc=1.
- Program with SUB making A=0, followed by JZ 7 → pc=7 after JZ's EXEC; with A=1 instead → pc=next sequential address.
- LOAD 3 with M[3]=0x2A → EXEC issues no Aload; LOAD2 has Aload=1, Asel=01, `mem_addr`=3; instruction takes 4 cycles.
- STORE 9 → `mem_we`=1 for exactly one cycle with `mem_addr`=9; Aload=0 throughout.
- pc=31 fetching a non-jump instruction → pc wraps to 0. HALT → `halted`=1, and `enter` pulses leave pc and controls unchanged.
- `reset`=0 asserted during LOAD2 → next cycle state=START, Aload=0, pc=0. With `CTRL_UNIT_SINGLE_STEP_EN`: no FETCH until `step` pulses.
